// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt sequencer: ExcCodes,
// CP0 Status bit positions and the sequencer state encoding.
package exc_pkg;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    localparam int ST_IE          = 0;
    localparam int ST_IM_SYSCALL  = 1;
    localparam int ST_IM_BREAK    = 2;
    localparam int ST_IM_TEQ      = 3;
    localparam int ST_IM_IRQ_BASE = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTER    = 3'd1,
        S_REDIRECT = 3'd2,
        S_HANDLER  = 3'd3,
        S_RETURN   = 3'd4,
        S_RESUME   = 3'd5
    } state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: multi-stage synchronizer, rising-edge detect and a
// pending latch that holds until the sequencer acknowledges it.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic ack,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   pending_r;
    logic                   rise_s;

    assign rise_s  = sync_r[SYNC_STAGES-1] & ~prev_r;
    assign pending = pending_r;

    // Synchronizer chain, edge history and pending latch; a new edge wins over an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r    <= '0;
            prev_r    <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], irq};
            prev_r    <= sync_r[SYNC_STAGES-1];
            pending_r <= rise_s | (pending_r & ~ack);
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: arbitrates sync exceptions and irqs, drives
// CP0 entry/return strobes and redirects the core PC to the handler and back.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004,
    parameter int          NUM_IRQ      = 3,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        pc,
    input  logic               syscall,
    input  logic               brk,
    input  logic               teq_exc,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [31:0]        status_in,
    input  logic [31:0]        epc_in,
    output logic               cp0_exc,
    output logic [4:0]         cp0_exc_code,
    output logic [31:0]        cp0_epc,
    output logic               cp0_eret,
    output logic               pc_redirect,
    output logic [31:0]        pc_target,
    output logic               stall,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               in_handler
);

    state_e               state_r, next_state_s;
    logic [NUM_IRQ-1:0]   pending_s;
    logic                 ev_s;
    logic [4:0]           ev_code_s;
    logic [NUM_IRQ-1:0]   ev_ack_s;
    logic                 unused_status_s;

    logic                 cp0_exc_d, cp0_eret_d, pc_redirect_d, stall_d, in_handler_d;
    logic [4:0]           cp0_exc_code_d;
    logic [31:0]          cp0_epc_d, pc_target_d;
    logic [NUM_IRQ-1:0]   irq_ack_d;

    logic                 cp0_exc_r, cp0_eret_r, pc_redirect_r, stall_r, in_handler_r;
    logic [4:0]           cp0_exc_code_r;
    logic [31:0]          cp0_epc_r, pc_target_r;
    logic [NUM_IRQ-1:0]   irq_ack_r;

    assign unused_status_s = ^status_in;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .irq     (irq[i]),
            .ack     (irq_ack_r[i]),
            .pending (pending_s[i])
        );
    end

    // Event arbitration; the descending irq loop leaves the lowest index as the winner.
    always_comb begin
        ev_s      = 1'b0;
        ev_code_s = EXC_INT;
        ev_ack_s  = '0;
        if (status_in[ST_IE]) begin
            if (teq_exc && status_in[ST_IM_TEQ]) begin
                ev_s      = 1'b1;
                ev_code_s = EXC_TEQ;
            end else if (brk && status_in[ST_IM_BREAK]) begin
                ev_s      = 1'b1;
                ev_code_s = EXC_BREAK;
            end else if (syscall && status_in[ST_IM_SYSCALL]) begin
                ev_s      = 1'b1;
                ev_code_s = EXC_SYSCALL;
            end else begin
                for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                    if (pending_s[i] && status_in[ST_IM_IRQ_BASE + i]) begin
                        ev_s      = 1'b1;
                        ev_code_s = EXC_INT;
                        ev_ack_s  = NUM_IRQ'(1) << i;
                    end else begin
                        ev_s      = ev_s;
                    end
                end
            end
        end else begin
            ev_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; an accepted event takes precedence over eret in IDLE.
    always_comb begin
        next_state_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (ev_s) begin
                    next_state_s = S_ENTER;
                end else if (eret) begin
                    next_state_s = S_RETURN;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ENTER:    next_state_s = S_REDIRECT;
            S_REDIRECT: next_state_s = S_HANDLER;
            S_HANDLER: begin
                if (eret) begin
                    next_state_s = S_RETURN;
                end else begin
                    next_state_s = S_HANDLER;
                end
            end
            S_RETURN:   next_state_s = S_RESUME;
            S_RESUME:   next_state_s = S_IDLE;
            default:    next_state_s = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so each register lines up with its state.
    always_comb begin
        cp0_exc_d      = 1'b0;
        cp0_exc_code_d = 5'd0;
        cp0_epc_d      = 32'h0000_0000;
        cp0_eret_d     = 1'b0;
        pc_redirect_d  = 1'b0;
        pc_target_d    = 32'h0000_0000;
        stall_d        = 1'b0;
        irq_ack_d      = '0;
        in_handler_d   = 1'b0;
        case (next_state_s)
            S_ENTER: begin
                cp0_exc_d      = 1'b1;
                cp0_exc_code_d = ev_code_s;
                cp0_epc_d      = pc;
                stall_d        = 1'b1;
                irq_ack_d      = ev_ack_s;
                in_handler_d   = 1'b1;
            end
            S_REDIRECT: begin
                pc_redirect_d = 1'b1;
                pc_target_d   = HANDLER_ADDR;
                in_handler_d  = 1'b1;
            end
            S_HANDLER: in_handler_d = 1'b1;
            S_RETURN: begin
                cp0_eret_d   = 1'b1;
                stall_d      = 1'b1;
                in_handler_d = 1'b1;
            end
            S_RESUME: begin
                pc_redirect_d = 1'b1;
                pc_target_d   = epc_in;
                in_handler_d  = 1'b1;
            end
            S_IDLE:  in_handler_d = 1'b0;
            default: in_handler_d = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cp0_exc_r      <= 1'b0;
            cp0_exc_code_r <= 5'd0;
            cp0_epc_r      <= 32'h0000_0000;
            cp0_eret_r     <= 1'b0;
            pc_redirect_r  <= 1'b0;
            pc_target_r    <= 32'h0000_0000;
            stall_r        <= 1'b0;
            irq_ack_r      <= '0;
            in_handler_r   <= 1'b0;
        end else begin
            cp0_exc_r      <= cp0_exc_d;
            cp0_exc_code_r <= cp0_exc_code_d;
            cp0_epc_r      <= cp0_epc_d;
            cp0_eret_r     <= cp0_eret_d;
            pc_redirect_r  <= pc_redirect_d;
            pc_target_r    <= pc_target_d;
            stall_r        <= stall_d;
            irq_ack_r      <= irq_ack_d;
            in_handler_r   <= in_handler_d;
        end
    end

    assign cp0_exc      = cp0_exc_r;
    assign cp0_exc_code = cp0_exc_code_r;
    assign cp0_epc      = cp0_epc_r;
    assign cp0_eret     = cp0_eret_r;
    assign pc_redirect  = pc_redirect_r;
    assign pc_target    = pc_target_r;
    assign stall        = stall_r;
    assign irq_ack      = irq_ack_r;
    assign in_handler   = in_handler_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl: entry, priority, irq masking,
// deferred irq service, eret return and asynchronous reset abort.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        syscall, brk, teq_exc, eret;
    logic [2:0]  irq;
    logic [31:0] status_in, epc_in;
    logic        cp0_exc, cp0_eret, pc_redirect, stall, in_handler;
    logic [4:0]  cp0_exc_code;
    logic [31:0] cp0_epc, pc_target;
    logic [2:0]  irq_ack;

    int checks   = 0;
    int failures = 0;
    bit ok;

    exc_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .syscall      (syscall),
        .brk          (brk),
        .teq_exc      (teq_exc),
        .eret         (eret),
        .irq          (irq),
        .status_in    (status_in),
        .epc_in       (epc_in),
        .cp0_exc      (cp0_exc),
        .cp0_exc_code (cp0_exc_code),
        .cp0_epc      (cp0_epc),
        .cp0_eret     (cp0_eret),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .stall        (stall),
        .irq_ack      (irq_ack),
        .in_handler   (in_handler)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_exc(input int budget, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            step();
            seen = cp0_exc;
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_ctl"}, {22'd0, cp0_exc, cp0_eret, pc_redirect, stall, in_handler, cp0_exc_code}, 32'h0);
        chk({tag, "_ack"}, {29'd0, irq_ack}, 32'h0);
        chk({tag, "_epc"}, cp0_epc | pc_target, 32'h0);
    endtask

    // From HANDLER: eret -> RETURN -> RESUME (redirect to epc) -> IDLE.
    task automatic do_return(input string tag, input logic [31:0] epc);
        epc_in = epc;
        eret   = 1'b1;
        step();
        eret = 1'b0;
        chk({tag, "_eret"}, {30'd0, cp0_eret, stall}, 32'h3);
        step();
        chk({tag, "_resume"}, {31'd0, pc_redirect}, 32'h1);
        chk({tag, "_tgt"}, pc_target, epc);
        step();
        chk({tag, "_idle"}, {29'd0, in_handler, pc_redirect, cp0_eret}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; pc = 32'h0; syscall = 1'b0; brk = 1'b0; teq_exc = 1'b0;
        eret = 1'b0; irq = 3'b000; status_in = 32'h0; epc_in = 32'h0;
        step();
        step();
        all_zero("reset");
        rst_n = 1'b1;
        step();

        // Syscall entry and handler redirect.
        status_in = 32'h0000_000F; pc = 32'h0000_0040; syscall = 1'b1;
        step();
        syscall = 1'b0;
        chk("sc_exc", {31'd0, cp0_exc}, 32'h1);
        chk("sc_code", {27'd0, cp0_exc_code}, 32'd8);
        chk("sc_epc", cp0_epc, 32'h0000_0040);
        chk("sc_stall", {31'd0, stall}, 32'h1);
        step();
        chk("sc_redir", {29'd0, pc_redirect, cp0_exc, stall}, 32'h4);
        chk("sc_tgt", pc_target, 32'h0000_0004);
        step();
        chk("sc_hand", {31'd0, in_handler}, 32'h1);
        chk("sc_tgt0", pc_target, 32'h0);
        do_return("ret80", 32'h0000_0080);

        // teq and syscall together: teq wins, one pulse; nested events ignored.
        pc = 32'h0000_0100; teq_exc = 1'b1; syscall = 1'b1;
        step();
        teq_exc = 1'b0; syscall = 1'b0;
        chk("teq_code", {26'd0, cp0_exc, cp0_exc_code}, {26'd0, 1'b1, 5'd13});
        step();
        chk("teq_single", {31'd0, cp0_exc}, 32'h0);
        step();
        brk = 1'b1;
        step();
        brk = 1'b0;
        chk("nest_ign", {30'd0, cp0_exc, in_handler}, 32'h1);
        do_return("ret_teq", 32'h0000_0104);

        // IE clear: brk ignored.
        status_in = 32'h0000_000E; brk = 1'b1;
        step();
        brk = 1'b0;
        chk("ie0_brk", {29'd0, cp0_exc, stall, in_handler}, 32'h0);
        step();
        chk("ie0_brk2", {30'd0, cp0_exc, pc_redirect}, 32'h0);

        // irq[2] with its mask clear stays pending; enabling the mask takes it.
        status_in = 32'h0000_0301; irq = 3'b100;
        for (int n = 0; n < 6; n++) step();
        chk("irq2_mask", {28'd0, cp0_exc, irq_ack}, 32'h0);
        irq = 3'b000;
        status_in = 32'h0000_0701;
        wait_exc(10, ok);
        chk("irq2_seen", {31'd0, ok}, 32'h1);
        chk("irq2_ack", {24'd0, cp0_exc_code, irq_ack}, {24'd0, 5'd0, 3'b100});
        step();
        step();
        do_return("ret_irq2", 32'h0000_0200);

        // irq[0] and irq[1] together: lowest first, irq[1] on first IDLE cycle.
        status_in = 32'h0000_0301; irq = 3'b011;
        wait_exc(10, ok);
        irq = 3'b000;
        chk("irq01_seen", {31'd0, ok}, 32'h1);
        chk("irq0_ack", {24'd0, cp0_exc_code, irq_ack}, {24'd0, 5'd0, 3'b001});
        step();
        chk("irq0_ack1cy", {29'd0, irq_ack}, 32'h0);
        step();
        do_return("ret_irq0", 32'h0000_0300);
        step();
        chk("irq1_ack", {28'd0, cp0_exc, irq_ack}, {28'd0, 1'b1, 3'b010});
        step();
        step();
        do_return("ret_irq1", 32'h0000_0304);

        // Reset during ENTER aborts immediately; nothing left pending afterwards.
        status_in = 32'h0000_000F; pc = 32'h0000_0500; syscall = 1'b1;
        step();
        syscall = 1'b0;
        chk("pre_rst", {31'd0, cp0_exc}, 32'h1);
        rst_n = 1'b0;
        #1;
        all_zero("rst_mid");
        step();
        rst_n = 1'b1;
        status_in = 32'h0000_070F;
        wait_exc(8, ok);
        chk("post_rst_quiet", {31'd0, ok}, 32'h0);
        chk("post_rst_idle", {30'd0, stall, in_handler}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer that drives the CP0 register file and redirects the single-cycle core's PC.
- Arbitrates synchronous exceptions (syscall, break, teq) and external interrupt lines, applies the CP0 Status masks, and issues one-cycle CP0 entry/return strobes with the selected ExcCode.
- Sequences entry, handler residency and eret return as an FSM, stalling the core while CP0 state is updated.

Parameters:
- HANDLER_ADDR, 32'h0000_0004, handler vector loaded into the PC on entry.
- NUM_IRQ, 3, number of external interrupt lines (1..5).
- SYNC_STAGES, 2, flip-flop stages in each irq synchronizer (>=2).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- pc  in  32  PC of the current instruction.
- syscall  in  1  current instruction is SYSCALL.
- brk  in  1  current instruction is BREAK.
- teq_exc  in  1  current instruction is TEQ with equal operands.
- eret  in  1  current instruction is ERET.
- irq  in  NUM_IRQ  asynchronous level interrupt lines.
- status_in  in  32  CP0 reg 12: bit0 IE; bits[3:1] IM for syscall/break/teq; bits[8+NUM_IRQ-1:8] irq mask.
- epc_in  in  32  CP0 reg 14.
- cp0_exc  out  1  one-cycle CP0 exception-entry strobe.
- cp0_exc_code  out  5  ExcCode for cp0_exc.
- cp0_epc  out  32  PC value for CP0 to write into EPC.
- cp0_eret  out  1  one-cycle CP0 status-restore strobe.
- pc_redirect  out  1  core loads pc_target next edge.
- pc_target  out  32  redirect address.
- stall  out  1  core holds PC and suppresses writeback.
- irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge of the serviced irq.
- in_handler  out  1  high from entry until return completes.

Behaviour:
- Reset (async, rst_n=0): FSM enters IDLE; synchronizers and pending bits cleared; all outputs 0. Reset mid-sequence aborts with no strobes.
- irq path: SYNC_STAGES synchronizer per line, then a rising-edge detect that sets pending[i]. pending[i] clears on irq_ack[i] and is otherwise held across all states.
- Accept condition (IDLE only): IE=1 and source mask bit=1.
- Priority, highest first: teq_exc (code 13), brk (9), syscall (8), then pending irq with lowest index first (code 0).
- Sync exceptions are sampled combinationally in the same cycle; irqs use registered pending bits.
- A masked sync exception is ignored (the instruction completes normally). A masked irq stays pending.
- FSM states and transitions:
  - IDLE: on an accepted event, go to ENTER and register the code and pc (capture). Eret with no event goes to RETURN. Event and eret together: the event wins.
  - ENTER (1 cycle): cp0_exc=1, cp0_exc_code and cp0_epc from capture, stall=1. If the source is an irq, pulse irq_ack. Next state is REDIRECT.
  - REDIRECT (1 cycle): pc_redirect=1, pc_target=HANDLER_ADDR, stall=0. Next state is HANDLER.
  - HANDLER: in_handler=1. All new events are ignored (no nesting); irqs keep pending. Eret goes to RETURN.
  - RETURN (1 cycle): cp0_eret=1, stall=1. Next state is RESUME.
  - RESUME (1 cycle): pc_redirect=1, pc_target=epc_in as sampled this cycle, so it reflects any mtc0 made in the handler. Next state is IDLE.
- Latency:
  - Exception instruction to handler fetch: 2 cycles.
  - Eret to EPC fetch: 2 cycles.
  - An irq edge becomes acceptable SYNC_STAGES+1 cycles after the input rises.
- Outputs are registered from the state and capture registers. cp0_exc and cp0_eret are never high together. pc_target=0 whenever pc_redirect=0.
- An irq still pending on the return to IDLE is accepted on the first IDLE cycle if still unmasked.

Decomposition:
- Shared package exc_pkg:
  - ExcCode constants: EXC_INT=0, EXC_SYSCALL=8, EXC_BREAK=9, EXC_TEQ=13.
  - Status bit-position constants.
  - FSM state enum.
- One sub-module, irq_sync_edge: synchronizer, edge detect and pending latch for one line, instantiated NUM_IRQ times.

Test Plan:
- status_in=32'h0000_000F, syscall=1 at pc=32'h0000_0040:
  - Next cycle: cp0_exc=1, code=8, cp0_epc=32'h40, stall=1.
  - Following cycle: pc_redirect=1, pc_target=32'h4.
- Simultaneous teq_exc=1 and syscall=1 with all masks set -> code=13 only; a single cp0_exc pulse.
- status_in=32'h0000_0301, irq[1] and irq[0] rise together -> ENTER with code 0 and irq_ack=3'b001. After eret returns, irq[1] is serviced on the first IDLE cycle with irq_ack=3'b010.
- In HANDLER, epc_in=32'h0000_0080, assert eret -> cp0_eret=1 with stall=1. Next cycle: pc_redirect=1, pc_target=32'h80. Then IDLE with in_handler=0.
- IE=0, brk=1 -> no strobes and stall=0. irq[2] rising with mask bit 10 clear -> pending held and no ack. Setting the mask bit afterwards triggers entry.
- Assert rst_n=0 during ENTER -> all outputs 0 immediately. After release: IDLE, no pending irq.
